// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: opcode/funct/ALU encodings, the ID/EX control word
// and the pipeline-control FSM states.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20,
    FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
    FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB  = 4'd3,
    ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2
  } regdst_t;

  typedef enum logic [1:0] {
    PC_NEXT = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_JR = 2'd3
  } pcsrc_t;

  typedef struct packed {
    aluop_t      alu_op;
    logic        ALUsrc;
    regdst_t     RegDst;
    logic        MemToReg;
    logic        JumpSel;
    logic        RegWr;
    logic        dREN;
    logic        dWEN;
    logic        ExtOp;
    logic        BNE;
    pcsrc_t      PCsrc;
    logic        halt;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [25:0] j25;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALTED = 2'd3
  } cu_state_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: IF/ID word -> control word, plus a flag
// telling the hazard logic whether the Rt field is a source operand.
module cu_decoder
  import cpu_types_pkg::*;
(
  input  logic [31:0] imemload,
  output ctrl_t       dec,
  output logic        uses_rt
);

  opcode_t op;
  funct_t  fn;
  ctrl_t   d;
  logic    rt_read;
  logic    valid;

  assign op = opcode_t'(imemload[31:26]);
  assign fn = funct_t'(imemload[5:0]);

  // Opcode/funct decode; anything unrecognised falls back to a NOP.
  always_comb begin
    d        = CTRL_NOP;
    rt_read  = 1'b0;
    valid    = 1'b1;
    d.Rs     = imemload[25:21];
    d.Rt     = imemload[20:16];
    d.Rd     = imemload[15:11];
    d.shamt  = imemload[10:6];
    d.imm16  = imemload[15:0];
    d.j25    = imemload[25:0];
    case (op)
      OP_RTYPE: begin
        d.RegDst = RD_RD;
        d.RegWr  = 1'b1;
        rt_read  = 1'b1;
        case (fn)
          FN_SLL:            d.alu_op = ALU_SLL;
          FN_SRL:            d.alu_op = ALU_SRL;
          FN_ADD, FN_ADDU:   d.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU:   d.alu_op = ALU_SUB;
          FN_AND:            d.alu_op = ALU_AND;
          FN_OR:             d.alu_op = ALU_OR;
          FN_XOR:            d.alu_op = ALU_XOR;
          FN_NOR:            d.alu_op = ALU_NOR;
          FN_SLT:            d.alu_op = ALU_SLT;
          FN_SLTU:           d.alu_op = ALU_SLTU;
          FN_JR: begin
            d.RegWr = 1'b0;
            d.PCsrc = PC_JR;
            rt_read = 1'b0;
          end
          default:           valid = 1'b0;
        endcase
      end
      OP_J:   d.PCsrc = PC_JUMP;
      OP_JAL: begin
        d.PCsrc   = PC_JUMP;
        d.JumpSel = 1'b1;
        d.RegDst  = RD_RA;
        d.RegWr   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.alu_op = ALU_SUB;
        d.ExtOp  = 1'b1;
        d.PCsrc  = PC_BRANCH;
        d.BNE    = (op == OP_BNE);
        rt_read  = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        d.ALUsrc = 1'b1;
        d.ExtOp  = 1'b1;
        d.RegWr  = 1'b1;
        d.alu_op = (op == OP_SLTI)  ? ALU_SLT :
                   (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.ALUsrc = 1'b1;
        d.RegWr  = 1'b1;
        d.alu_op = (op == OP_ANDI) ? ALU_AND :
                   (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      // LUI is executed as a 16-bit left shift of the zero-extended immediate.
      OP_LUI: begin
        d.ALUsrc = 1'b1;
        d.RegWr  = 1'b1;
        d.alu_op = ALU_SLL;
        d.shamt  = 5'd16;
      end
      OP_LW: begin
        d.ALUsrc   = 1'b1;
        d.ExtOp    = 1'b1;
        d.RegWr    = 1'b1;
        d.dREN     = 1'b1;
        d.MemToReg = 1'b1;
        d.alu_op   = ALU_ADD;
      end
      OP_SW: begin
        d.ALUsrc = 1'b1;
        d.ExtOp  = 1'b1;
        d.dWEN   = 1'b1;
        d.alu_op = ALU_ADD;
        rt_read  = 1'b1;
      end
      OP_HALT: begin
        d      = CTRL_NOP;
        d.halt = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

  assign dec     = valid ? d : CTRL_NOP;
  assign uses_rt = valid & rt_read;

endmodule

// File: rtl/pipeline_control_unit.sv
// ID-stage control: decode into the ID/EX control register plus stall/flush/halt
// sequencing. Define CU_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_control_unit
  import cpu_types_pkg::*;
#(
  parameter int REDIRECT_PENALTY = 2,
  parameter int LOADUSE_BUBBLES  = 1,
  parameter int CNT_W            = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      imemload,
  input  logic             ihit,
  input  logic             mem_wait,
  input  logic             ex_redirect,
  input  logic [4:0]       idex_fwd_Rt,
  output ctrl_t            ctrl,
  output logic             stall_if,
  output logic             flush_ifid,
  output logic             imemREN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BUB_W = $clog2(8);
  localparam logic [BUB_W-1:0] REDIR_RELOAD = BUB_W'(REDIRECT_PENALTY - 1);
  localparam logic [BUB_W-1:0] LU_RELOAD    = BUB_W'(LOADUSE_BUBBLES - 1);
  localparam logic [BUB_W-1:0] CNT_ONE      = BUB_W'(1);
  localparam cu_state_t REDIR_STATE = (REDIRECT_PENALTY > 1) ? FLUSH : RUN;
  localparam cu_state_t LU_STATE    = (LOADUSE_BUBBLES > 1)  ? STALL : RUN;

  if (REDIRECT_PENALTY < 1 || REDIRECT_PENALTY > 7) begin : g_bad_redirect
    $error("pipeline_control_unit: REDIRECT_PENALTY must be in 1..7");
  end
  if (LOADUSE_BUBBLES < 1 || LOADUSE_BUBBLES > 7) begin : g_bad_loaduse
    $error("pipeline_control_unit: LOADUSE_BUBBLES must be in 1..7");
  end

  cu_state_t        state_r, state_s;
  logic [BUB_W-1:0] cnt_r, cnt_s;
  ctrl_t            ctrl_r, ctrl_s;
  ctrl_t            dec_s;
  logic             uses_rt_s;
  logic             frozen_s;
  logic             hazard_s;
  logic             stall_s;
  logic             flush_s;

  cu_decoder u_decoder (
    .imemload (imemload),
    .dec      (dec_s),
    .uses_rt  (uses_rt_s)
  );

  assign frozen_s = mem_wait | ~ihit;

  // The load in EX writes a register the instruction in ID is about to read.
  assign hazard_s = ctrl_r.dREN & ctrl_r.RegWr & (idex_fwd_Rt != 5'd0) &
                    ((idex_fwd_Rt == dec_s.Rs) |
                     (uses_rt_s & (idex_fwd_Rt == dec_s.Rt)));

  // Next-state, bubble counter and ID/EX control word selection.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ctrl_s  = ctrl_r;
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (state_r == HALTED) begin
      stall_s = 1'b1;
      ctrl_s  = CTRL_NOP;
    end else if (frozen_s) begin
      stall_s = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_redirect) begin
            flush_s = 1'b1;
            ctrl_s  = CTRL_NOP;
            state_s = REDIR_STATE;
            cnt_s   = REDIR_RELOAD;
          end else if (dec_s.halt) begin
            ctrl_s  = dec_s;
            state_s = HALTED;
          end else if (hazard_s) begin
            stall_s = 1'b1;
            ctrl_s  = CTRL_NOP;
            state_s = LU_STATE;
            cnt_s   = LU_RELOAD;
          end else begin
            ctrl_s  = dec_s;
          end
        end
        STALL: begin
          ctrl_s = CTRL_NOP;
          if (ex_redirect) begin
            flush_s = 1'b1;
            state_s = REDIR_STATE;
            cnt_s   = REDIR_RELOAD;
          end else begin
            stall_s = 1'b1;
            cnt_s   = cnt_r - CNT_ONE;
            state_s = (cnt_r == CNT_ONE) ? RUN : STALL;
          end
        end
        FLUSH: begin
          ctrl_s  = CTRL_NOP;
          flush_s = 1'b1;
          if (ex_redirect) begin
            cnt_s   = REDIR_RELOAD;
          end else begin
            cnt_s   = cnt_r - CNT_ONE;
            state_s = (cnt_r == CNT_ONE) ? RUN : FLUSH;
          end
        end
        default: begin
          state_s = RUN;
          cnt_s   = '0;
          ctrl_s  = CTRL_NOP;
        end
      endcase
    end
  end

  // FSM state, bubble counter and ID/EX control register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= RUN;
      cnt_r   <= '0;
      ctrl_r  <= CTRL_NOP;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ctrl_r  <= ctrl_s;
    end
  end

  assign ctrl       = ctrl_r;
  assign stall_if   = stall_s;
  assign flush_ifid = flush_s;
  assign halt       = (state_r == HALTED);
  assign imemREN    = (state_r != HALTED);

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             stall_inc_s;

  assign stall_inc_s = ~frozen_s & stall_s & ((state_r == RUN) | (state_r == STALL));

  // Saturating stall/flush event counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_inc_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_s && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench: two control units (LOADUSE_BUBBLES 1 and 2, REDIRECT_PENALTY 3)
// share stimulus; each task checks one sequencing scenario.
module tb_pipeline_control_unit;
  import cpu_types_pkg::*;

  localparam int CNT_W = 32;
`ifdef CU_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [31:0] I_LW2   = 32'h8C22_0000; // lw   $2,0($1)
  localparam logic [31:0] I_LW0   = 32'h8C20_0000; // lw   $0,0($1)
  localparam logic [31:0] I_LW5   = 32'h8C25_0000; // lw   $5,0($1)
  localparam logic [31:0] I_ADD   = 32'h0044_1820; // add  $3,$2,$4
  localparam logic [31:0] I_ADD0  = 32'h0004_1820; // add  $3,$0,$4
  localparam logic [31:0] I_ORI   = 32'h34E5_0001; // ori  $5,$7,1
  localparam logic [31:0] I_SW5   = 32'hAC25_0000; // sw   $5,0($1)
  localparam logic [31:0] I_HALT  = 32'hFFFF_FFFF;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [31:0]      imemload = 32'd0;
  logic             ihit = 1'b1;
  logic             mem_wait = 1'b0;
  logic             ex_redirect = 1'b0;
  logic [4:0]       idex_fwd_Rt = 5'd0;

  ctrl_t            ctrl1, ctrl2;
  logic             stall1, stall2, flush1, flush2, ren1, ren2, halt1, halt2;
  logic [CNT_W-1:0] scnt1, scnt2, fcnt1, fcnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  pipeline_control_unit #(.REDIRECT_PENALTY(3), .LOADUSE_BUBBLES(1), .CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .RST(RST), .imemload(imemload), .ihit(ihit), .mem_wait(mem_wait),
    .ex_redirect(ex_redirect), .idex_fwd_Rt(idex_fwd_Rt), .ctrl(ctrl1),
    .stall_if(stall1), .flush_ifid(flush1), .imemREN(ren1), .halt(halt1),
    .stall_cnt(scnt1), .flush_cnt(fcnt1));

  pipeline_control_unit #(.REDIRECT_PENALTY(3), .LOADUSE_BUBBLES(2), .CNT_W(CNT_W)) u_dut2 (
    .CLK(CLK), .RST(RST), .imemload(imemload), .ihit(ihit), .mem_wait(mem_wait),
    .ex_redirect(ex_redirect), .idex_fwd_Rt(idex_fwd_Rt), .ctrl(ctrl2),
    .stall_if(stall2), .flush_ifid(flush2), .imemREN(ren2), .halt(halt2),
    .stall_cnt(scnt2), .flush_cnt(fcnt2));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; imemload = 32'd0; ihit = 1'b1; mem_wait = 1'b0;
    ex_redirect = 1'b0; idex_fwd_Rt = 5'd0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b1;
    #1;
    n_tests++; if (ctrl1 !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", ctrl1); end
    n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL reset_stall_if: got %b want 0", stall1); end
    n_tests++; if (flush1 !== 1'b0) begin n_fail++; $display("FAIL reset_flush_ifid: got %b want 0", flush1); end
    n_tests++; if (ren1 !== 1'b1) begin n_fail++; $display("FAIL reset_imemREN: got %b want 1", ren1); end
    n_tests++; if (halt1 !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", halt1); end
    n_tests++; if (scnt1 !== '0 || fcnt1 !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", scnt1, fcnt1); end
    tick();
    RST = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    imemload = I_LW2;
    tick();
    n_tests++; if (ctrl1.dREN !== 1'b1 || ctrl1.RegWr !== 1'b1 || ctrl1.Rt !== 5'd2) begin n_fail++; $display("FAIL lu_lw_decode: got dREN=%b RegWr=%b Rt=%0d want 1 1 2", ctrl1.dREN, ctrl1.RegWr, ctrl1.Rt); end
    imemload = I_ADD; idex_fwd_Rt = 5'd2;
    #1;
    n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL lu_stall_if: got %b want 1", stall1); end
    tick();
    n_tests++; if (ctrl1 !== '0) begin n_fail++; $display("FAIL lu_bubble: got %h want 0", ctrl1); end
    idex_fwd_Rt = 5'd0;
    #1;
    n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", stall1); end
    tick();
    n_tests++; if (ctrl1.Rd !== 5'd3 || ctrl1.RegWr !== 1'b1 || ctrl1.alu_op !== ALU_ADD || ctrl1.RegDst !== RD_RD) begin n_fail++; $display("FAIL lu_add_decode: got Rd=%0d RegWr=%b alu=%0d want 3 1 %0d", ctrl1.Rd, ctrl1.RegWr, ctrl1.alu_op, ALU_ADD); end
    n_tests++; if (scnt1 !== CNT_W'(PERF)) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", scnt1, PERF); end
  endtask

  task automatic test_hazard_operands();
    do_reset();
    imemload = I_LW0;
    tick();
    imemload = I_ADD0; idex_fwd_Rt = 5'd0;
    #1;
    n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL r0_no_stall: got %b want 0", stall1); end
    tick();
    n_tests++; if (ctrl1.Rd !== 5'd3 || ctrl1.Rs !== 5'd0) begin n_fail++; $display("FAIL r0_decode: got Rd=%0d Rs=%0d want 3 0", ctrl1.Rd, ctrl1.Rs); end
    imemload = I_LW5;
    tick();
    imemload = I_ORI; idex_fwd_Rt = 5'd5;
    #1;
    n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL ori_rt_no_stall: got %b want 0", stall1); end
    tick();
    n_tests++; if (ctrl1.imm16 !== 16'd1 || ctrl1.ALUsrc !== 1'b1 || ctrl1.alu_op !== ALU_OR || ctrl1.ExtOp !== 1'b0) begin n_fail++; $display("FAIL ori_decode: got imm=%0d ALUsrc=%b alu=%0d ExtOp=%b want 1 1 %0d 0", ctrl1.imm16, ctrl1.ALUsrc, ctrl1.alu_op, ctrl1.ExtOp, ALU_OR); end
    imemload = I_LW5; idex_fwd_Rt = 5'd0;
    tick();
    imemload = I_SW5; idex_fwd_Rt = 5'd5;
    #1;
    n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL sw_rt_stall: got %b want 1", stall1); end
    tick();
    idex_fwd_Rt = 5'd0;
  endtask

  task automatic test_redirect();
    logic exp;
    do_reset();
    imemload = I_ADD; ex_redirect = 1'b1;
    #1;
    n_tests++; if (flush1 !== 1'b1) begin n_fail++; $display("FAIL redir_first: got %b want 1", flush1); end
    tick();
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = (i < 2);
      #1;
      n_tests++; if (flush1 !== exp || ctrl1 !== '0) begin n_fail++; $display("FAIL redir_cycle%0d: got flush=%b ctrl=%h want %b 0", i, flush1, ctrl1, exp); end
      tick();
    end
    n_tests++; if (ctrl1.Rd !== 5'd3) begin n_fail++; $display("FAIL redir_resume: got Rd=%0d want 3", ctrl1.Rd); end
    n_tests++; if (fcnt1 !== CNT_W'(3 * PERF)) begin n_fail++; $display("FAIL redir_flush_cnt: got %0d want %0d", fcnt1, 3 * PERF); end
  endtask

  task automatic test_redirect_restart();
    logic exp;
    do_reset();
    imemload = I_ADD; ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    tick();
    ex_redirect = 1'b1;
    #1;
    n_tests++; if (flush1 !== 1'b1) begin n_fail++; $display("FAIL restart_flush: got %b want 1", flush1); end
    tick();
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = (i < 2);
      #1;
      n_tests++; if (flush1 !== exp) begin n_fail++; $display("FAIL restart_cycle%0d: got %b want %b", i, flush1, exp); end
      tick();
    end
    n_tests++; if (fcnt1 !== CNT_W'(5 * PERF)) begin n_fail++; $display("FAIL restart_flush_cnt: got %0d want %0d", fcnt1, 5 * PERF); end
  endtask

  task automatic test_stall_redirect();
    logic exp;
    do_reset();
    imemload = I_LW2;
    tick();
    imemload = I_ADD; idex_fwd_Rt = 5'd2;
    #1;
    n_tests++; if (stall2 !== 1'b1) begin n_fail++; $display("FAIL lu2_first: got %b want 1", stall2); end
    tick();
    idex_fwd_Rt = 5'd0;
    #1;
    n_tests++; if (stall2 !== 1'b1 || ctrl2 !== '0) begin n_fail++; $display("FAIL lu2_second: got stall=%b ctrl=%h want 1 0", stall2, ctrl2); end
    tick();
    #1;
    n_tests++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL lu2_release: got %b want 0", stall2); end
    tick();
    n_tests++; if (ctrl2.Rd !== 5'd3) begin n_fail++; $display("FAIL lu2_decode: got Rd=%0d want 3", ctrl2.Rd); end
    imemload = I_LW2;
    tick();
    imemload = I_ADD; idex_fwd_Rt = 5'd2;
    tick();
    idex_fwd_Rt = 5'd0; ex_redirect = 1'b1;
    #1;
    n_tests++; if (flush2 !== 1'b1 || stall2 !== 1'b0) begin n_fail++; $display("FAIL stall_preempt: got flush=%b stall=%b want 1 0", flush2, stall2); end
    tick();
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = (i < 2);
      #1;
      n_tests++; if (flush2 !== exp) begin n_fail++; $display("FAIL preempt_cycle%0d: got %b want %b", i, flush2, exp); end
      tick();
    end
    n_tests++; if (ctrl2.Rd !== 5'd3) begin n_fail++; $display("FAIL preempt_resume: got Rd=%0d want 3", ctrl2.Rd); end
  endtask

  task automatic test_redirect_and_loaduse();
    do_reset();
    imemload = I_LW2;
    tick();
    imemload = I_ADD; idex_fwd_Rt = 5'd2; ex_redirect = 1'b1;
    #1;
    n_tests++; if (flush1 !== 1'b1 || stall1 !== 1'b0) begin n_fail++; $display("FAIL both_events: got flush=%b stall=%b want 1 0", flush1, stall1); end
    tick();
    n_tests++; if (ctrl1 !== '0) begin n_fail++; $display("FAIL both_ctrl: got %h want 0", ctrl1); end
    ex_redirect = 1'b0; idex_fwd_Rt = 5'd0;
  endtask

  task automatic test_mem_wait();
    logic exp;
    do_reset();
    imemload = I_ADD; ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0; mem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_redirect = (i == 1);
      #1;
      n_tests++; if (stall1 !== 1'b1 || flush1 !== 1'b0) begin n_fail++; $display("FAIL freeze%0d: got stall=%b flush=%b want 1 0", i, stall1, flush1); end
      tick();
    end
    mem_wait = 1'b0; ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = (i < 2);
      #1;
      n_tests++; if (flush1 !== exp) begin n_fail++; $display("FAIL thaw_cycle%0d: got %b want %b", i, flush1, exp); end
      tick();
    end
    n_tests++; if (ctrl1.Rd !== 5'd3) begin n_fail++; $display("FAIL thaw_resume: got Rd=%0d want 3", ctrl1.Rd); end
    n_tests++; if (fcnt1 !== CNT_W'(3 * PERF)) begin n_fail++; $display("FAIL thaw_flush_cnt: got %0d want %0d", fcnt1, 3 * PERF); end
    imemload = I_LW2; ihit = 1'b0;
    #1;
    n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL ihit_stall: got %b want 1", stall1); end
    tick();
    n_tests++; if (ctrl1.Rd !== 5'd3 || ctrl1.dREN !== 1'b0) begin n_fail++; $display("FAIL ihit_hold: got Rd=%0d dREN=%b want 3 0", ctrl1.Rd, ctrl1.dREN); end
    ihit = 1'b1;
    tick();
    n_tests++; if (ctrl1.dREN !== 1'b1) begin n_fail++; $display("FAIL ihit_resume: got dREN=%b want 1", ctrl1.dREN); end
  endtask

  task automatic test_halt();
    do_reset();
    imemload = I_HALT;
    #1;
    n_tests++; if (halt1 !== 1'b0 || ren1 !== 1'b1) begin n_fail++; $display("FAIL halt_before: got halt=%b ren=%b want 0 1", halt1, ren1); end
    tick();
    n_tests++; if (halt1 !== 1'b1 || ren1 !== 1'b0 || ctrl1.halt !== 1'b1 || stall1 !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got halt=%b ren=%b ctrl.halt=%b stall=%b want 1 0 1 1", halt1, ren1, ctrl1.halt, stall1); end
    imemload = I_ADD; ex_redirect = 1'b1;
    tick();
    n_tests++; if (halt1 !== 1'b1 || ctrl1 !== '0 || flush1 !== 1'b0 || stall1 !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got halt=%b ctrl=%h flush=%b stall=%b want 1 0 0 1", halt1, ctrl1, flush1, stall1); end
    ex_redirect = 1'b0; RST = 1'b1;
    #1;
    n_tests++; if (halt1 !== 1'b0 || ren1 !== 1'b1 || ctrl1 !== '0 || stall1 !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got halt=%b ren=%b ctrl=%h stall=%b want 0 1 0 0", halt1, ren1, ctrl1, stall1); end
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    imemload = I_ADD; ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    #1;
    n_tests++; if (flush1 !== 1'b1) begin n_fail++; $display("FAIL midflush_active: got %b want 1", flush1); end
    RST = 1'b1;
    #1;
    n_tests++; if (flush1 !== 1'b0 || ctrl1 !== '0) begin n_fail++; $display("FAIL midflush_reset: got flush=%b ctrl=%h want 0 0", flush1, ctrl1); end
    tick();
    RST = 1'b0;
    #1;
    n_tests++; if (flush1 !== 1'b0) begin n_fail++; $display("FAIL midflush_no_pending: got %b want 0", flush1); end
    tick();
    n_tests++; if (ctrl1.Rd !== 5'd3) begin n_fail++; $display("FAIL midflush_decode: got Rd=%0d want 3", ctrl1.Rd); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hazard_operands();
    test_redirect();
    test_redirect_restart();
    test_stall_redirect();
    test_redirect_and_loaduse();
    test_mem_wait();
    test_halt();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
